// File: rtl/adc_frame_aligner.sv
// Purpose: frame-clock alignment FSM; bitslips the lane deserializers until the frame word matches, then holds lock.
// Latency: Aligned rises SettleCycles+MatchCount+1 cycles after Start when the frame word is already aligned.
// Backpressure: none; consumes one FrameWord per FrmClk, and DataLine words are usable only while Aligned is high.
module adc_frame_aligner #(
    parameter int          AdcBits      = 14,
    parameter logic [15:0] FramePattern = 16'h3F80,
    parameter int          SettleCycles = 4,
    parameter int          MatchCount   = 8,
    parameter int          LossCount    = 4,
    parameter int          MaxSlips     = AdcBits
) (
    input  logic        FrmClk,
    input  logic        FrmRst_n,
    input  logic        Start,
    input  logic [15:0] FrameWord,
    output logic        BitSlip,
    output logic        Aligned,
    output logic        AlignFail,
    output logic [4:0]  SlipCnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Only the low AdcBits of the frame word carry the frame pattern.
    localparam logic [15:0] CMP_MASK    = 16'((32'h1 << AdcBits) - 32'h1);
    // Counters compare against "last value" so a count of N takes exactly N cycles.
    localparam logic [3:0]  SETTLE_LAST = 4'(SettleCycles - 1);
    localparam logic [3:0]  MATCH_LAST  = 4'(MatchCount - 1);
    localparam logic [3:0]  LOSS_LAST   = 4'(LossCount - 1);
    localparam logic [4:0]  SLIP_MAX    = 5'(MaxSlips);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  run_q, run_d;
    logic [4:0]  slip_cnt_q, slip_cnt_d;
    logic        bit_slip_q, bit_slip_d;
    logic        aligned_q, aligned_d;
    logic        align_fail_q, align_fail_d;
    logic        match;

    // Frame word matches the expected pattern in the compared bits.
    always_comb begin
        match = ((FrameWord ^ FramePattern) & CMP_MASK) == 16'h0000;
    end

    // Next-state, counter and registered-output decode; Start overrides every state.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        run_d      = run_q;
        slip_cnt_d = slip_cnt_q;
        if (Start) begin
            state_d    = ST_SETTLE;
            wait_d     = 4'd0;
            run_d      = 4'd0;
            slip_cnt_d = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (wait_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                        wait_d  = 4'd0;
                        run_d   = 4'd0;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        if (run_q == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else if (slip_cnt_q == SLIP_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    // The pulse is this state's registered output; the count lands as we leave.
                    state_d = ST_SETTLE;
                    wait_d  = 4'd0;
                    if (slip_cnt_q != 5'd31) begin
                        slip_cnt_d = slip_cnt_q + 5'd1;
                    end
                end
                ST_LOCKED: begin
                    // Run counter tracks consecutive misses; any hit forgives them.
                    if (match) begin
                        run_d = 4'd0;
                    end else if (run_q == LOSS_LAST) begin
                        state_d    = ST_SETTLE;
                        wait_d     = 4'd0;
                        run_d      = 4'd0;
                        slip_cnt_d = 5'd0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        bit_slip_d   = (state_d == ST_SLIP);
        aligned_d    = (state_d == ST_LOCKED);
        align_fail_d = (state_d == ST_FAIL);
    end

    // State, counters and outputs; reset drops everything to IDLE at once.
    always_ff @(posedge FrmClk or negedge FrmRst_n) begin
        if (!FrmRst_n) begin
            state_q      <= ST_IDLE;
            wait_q       <= 4'd0;
            run_q        <= 4'd0;
            slip_cnt_q   <= 5'd0;
            bit_slip_q   <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            run_q        <= run_d;
            slip_cnt_q   <= slip_cnt_d;
            bit_slip_q   <= bit_slip_d;
            aligned_q    <= aligned_d;
            align_fail_q <= align_fail_d;
        end
    end

    assign BitSlip   = bit_slip_q;
    assign Aligned   = aligned_q;
    assign AlignFail = align_fail_q;
    assign SlipCnt   = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Purpose: scoreboard bench for adc_frame_aligner with directed frame-word sequences and a bitslip channel model.
// Latency: expectations carry absolute cycle numbers; a cycle index advances on every FrmClk rising edge.
// Backpressure: none; the monitor samples outputs on every falling edge and pops expectations as they fall due.
module tb_adc_frame_aligner;

    logic        FrmClk = 1'b0;
    logic        FrmRst_n;
    logic        Start;
    logic [15:0] FrameWord;
    logic        BitSlip;
    logic        Aligned;
    logic        AlignFail;
    logic [4:0]  SlipCnt;

    logic [15:0] fw_direct;
    logic [15:0] fw_model;
    bit          use_model = 1'b0;
    int          offset    = 11;
    int          cyc       = 0;
    bit          done      = 1'b0;
    int          checks    = 0;
    int          failures  = 0;
    logic        prev_al   = 1'b0;
    logic        prev_af   = 1'b0;

    typedef struct {
        int         cyc;
        logic       bs;
        logic       al;
        logic       af;
        logic [4:0] sc;
        int         tag;
    } exp_t;

    exp_t evt_q[$];
    exp_t lvl_q[$];

    localparam logic [13:0] PAT14 = 14'h3F80;

    adc_frame_aligner dut (
        .FrmClk    (FrmClk),
        .FrmRst_n  (FrmRst_n),
        .Start     (Start),
        .FrameWord (FrameWord),
        .BitSlip   (BitSlip),
        .Aligned   (Aligned),
        .AlignFail (AlignFail),
        .SlipCnt   (SlipCnt)
    );

    always #5 FrmClk = ~FrmClk;

    always @(posedge FrmClk) cyc <= cyc + 1;

    function automatic logic [13:0] rotl14(input logic [13:0] x, input int n);
        logic [27:0] t;
        t = {x, x} << n;
        return t[27:14];
    endfunction

    // Deserializer model: each bitslip rotates the received pattern left by one bit.
    assign fw_model  = {2'b00, rotl14(PAT14, offset)};
    assign FrameWord = use_model ? fw_model : fw_direct;

    always @(negedge FrmClk) begin
        if (!use_model) offset = 11;
        else if (BitSlip) offset = (offset + 1) % 14;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge FrmClk);
    endtask

    task automatic push_evt(input int c, input logic bs, input logic al, input logic af,
                            input logic [4:0] sc, input int tag);
        exp_t e;
        e.cyc = c; e.bs = bs; e.al = al; e.af = af; e.sc = sc; e.tag = tag;
        evt_q.push_back(e);
    endtask

    task automatic push_lvl(input int c, input logic bs, input logic al, input logic af,
                            input logic [4:0] sc, input int tag);
        exp_t e;
        e.cyc = c; e.bs = bs; e.al = al; e.af = af; e.sc = sc; e.tag = tag;
        lvl_q.push_back(e);
    endtask

    // Monitor: level checks at scheduled cycles, event checks whenever an output pulses or toggles.
    always @(negedge FrmClk) begin : monitor
        exp_t e;
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            checks++;
            if (e.cyc != cyc || {BitSlip, Aligned, AlignFail, SlipCnt} !== {e.bs, e.al, e.af, e.sc}) begin
                failures++;
                $display("FAIL level tag=%0d at cyc=%0d: got bs=%b al=%b af=%b sc=%0d, want cyc=%0d bs=%b al=%b af=%b sc=%0d",
                         e.tag, cyc, BitSlip, Aligned, AlignFail, SlipCnt, e.cyc, e.bs, e.al, e.af, e.sc);
            end
        end
        if (BitSlip !== 1'b0 || Aligned !== prev_al || AlignFail !== prev_af) begin
            checks++;
            if (evt_q.size() == 0) begin
                failures++;
                $display("FAIL event unexpected at cyc=%0d: got bs=%b al=%b af=%b sc=%0d, want none",
                         cyc, BitSlip, Aligned, AlignFail, SlipCnt);
            end else begin
                e = evt_q.pop_front();
                if (e.cyc != cyc || {BitSlip, Aligned, AlignFail, SlipCnt} !== {e.bs, e.al, e.af, e.sc}) begin
                    failures++;
                    $display("FAIL event tag=%0d: got cyc=%0d bs=%b al=%b af=%b sc=%0d, want cyc=%0d bs=%b al=%b af=%b sc=%0d",
                             e.tag, cyc, BitSlip, Aligned, AlignFail, SlipCnt, e.cyc, e.bs, e.al, e.af, e.sc);
                end
            end
        end
        prev_al = Aligned;
        prev_af = AlignFail;
        if (done) begin
            checks++;
            if (evt_q.size() != 0 || lvl_q.size() != 0) begin
                failures++;
                $display("FAIL pending: got %0d events and %0d levels never seen, want 0 and 0",
                         evt_q.size(), lvl_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s;
        int c0;
        logic [15:0] seq [8];
        FrmRst_n  = 1'b0;
        Start     = 1'b0;
        fw_direct = 16'h0000;

        // Reset held: random words and Start pulses must leave every output low.
        tick(1);
        c0 = cyc;
        push_lvl(c0 + 1, 0, 0, 0, 5'd0, 1);
        push_lvl(c0 + 4, 0, 0, 0, 5'd0, 2);
        push_lvl(c0 + 7, 0, 0, 0, 5'd0, 3);
        for (int i = 0; i < 8; i++) begin
            fw_direct = 16'($urandom);
            Start     = 1'($urandom_range(0, 1));
            tick(1);
        end
        Start    = 1'b0;
        FrmRst_n = 1'b1;
        c0 = cyc;
        push_lvl(c0 + 2, 0, 0, 0, 5'd0, 4);
        push_lvl(c0 + 9, 0, 0, 0, 5'd0, 5);
        tick(12);

        // Immediate lock: aligned word, no slips, Aligned at Start+13.
        fw_direct = 16'h3F80;
        Start = 1'b1;
        s = cyc;
        push_lvl(s + 12, 0, 0, 0, 5'd0, 6);
        push_evt(s + 13, 0, 1, 0, 5'd0, 20);
        push_lvl(s + 20, 0, 1, 0, 5'd0, 7);
        tick(1);
        Start = 1'b0;
        tick(23);

        // Loss: 3 misses, 1 hit (upper bits set, ignored), 4 misses -> drop, then relock.
        seq[0] = 16'h0000; seq[1] = 16'h3F81; seq[2] = 16'h1F80; seq[3] = 16'hFF80;
        seq[4] = 16'h3F00; seq[5] = 16'h3FC0; seq[6] = 16'h0080; seq[7] = 16'h2A55;
        s = cyc;
        push_lvl(s + 7, 0, 1, 0, 5'd0, 8);
        push_evt(s + 8, 0, 0, 0, 5'd0, 21);
        push_evt(s + 20, 0, 1, 0, 5'd0, 22);
        for (int i = 0; i < 8; i++) begin
            fw_direct = seq[i];
            tick(1);
        end
        fw_direct = 16'h3F80;
        tick(15);

        // Start while locked: Aligned drops next cycle, then relocks.
        Start = 1'b1;
        s = cyc;
        push_evt(s + 1, 0, 0, 0, 5'd0, 23);
        push_evt(s + 13, 0, 1, 0, 5'd0, 24);
        tick(1);
        Start = 1'b0;
        tick(15);

        // Rotated channel three bits off: three slips six cycles apart, then lock with SlipCnt=3.
        use_model = 1'b1;
        Start = 1'b1;
        s = cyc;
        push_evt(s + 1, 0, 0, 0, 5'd0, 25);
        push_evt(s + 6, 1, 0, 0, 5'd0, 26);
        push_evt(s + 12, 1, 0, 0, 5'd1, 27);
        push_evt(s + 18, 1, 0, 0, 5'd2, 28);
        push_lvl(s + 25, 0, 0, 0, 5'd3, 9);
        push_evt(s + 31, 0, 1, 0, 5'd3, 29);
        tick(1);
        Start = 1'b0;
        tick(34);
        use_model = 1'b0;
        tick(2);

        // Failure: all-zero word, 14 slips, then sticky AlignFail until the next Start.
        fw_direct = 16'h0000;
        Start = 1'b1;
        s = cyc;
        push_evt(s + 1, 0, 0, 0, 5'd0, 30);
        for (int k = 0; k < 14; k++) push_evt(s + 6 + 6 * k, 1, 0, 0, 5'(k), 31 + k);
        push_lvl(s + 89, 0, 0, 0, 5'd14, 10);
        push_evt(s + 90, 0, 0, 1, 5'd14, 50);
        tick(1);
        Start = 1'b0;
        tick(94);
        fw_direct = 16'h3F80;
        Start = 1'b1;
        s = cyc;
        push_evt(s + 1, 0, 0, 0, 5'd0, 51);
        push_evt(s + 13, 0, 1, 0, 5'd0, 52);
        tick(1);
        Start = 1'b0;
        tick(15);

        // Reset landing in the SLIP cycle: the pulse never reaches a sample point, outputs return to idle.
        fw_direct = 16'h0000;
        Start = 1'b1;
        s = cyc;
        push_evt(s + 1, 0, 0, 0, 5'd0, 53);
        push_lvl(s + 6, 0, 0, 0, 5'd0, 11);
        push_lvl(s + 8, 0, 0, 0, 5'd0, 12);
        tick(1);
        Start = 1'b0;
        tick(4);
        @(posedge FrmClk);
        #1 FrmRst_n = 1'b0;
        tick(3);
        FrmRst_n = 1'b1;
        tick(1);

        // Clean lock after the reset.
        fw_direct = 16'h3F80;
        Start = 1'b1;
        s = cyc;
        push_lvl(s + 10, 0, 0, 0, 5'd0, 13);
        push_evt(s + 13, 0, 1, 0, 5'd0, 54);
        tick(1);
        Start = 1'b0;
        tick(18);

        done = 1'b1;
        tick(3);
    end

endmodule
